if_id_queue: RTL and testbench

Instruction queue between the IF stage and the ID stage of the five-stage RISC-V pipeline. Each cycle it captures the `{pc, ir, ra}` triple fetched by IF and presents the oldest buffered triple to ID with a valid/ready handshake. It generates the IF stall whenever it is full. A branch/jump flush empties it in one cycle. It decouples fetch from decode stalls, so IF keeps fetching while ID is held for up to DEPTH instructions.

---
 rtl/if_id_queue.sv | 89 ++++++++
 tb/tb_if_id_queue.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: circular buffer of {pc, ir, ra} triples between
// fetch and decode. It presents the oldest entry to ID with a valid/ready
// handshake, stalls IF when full, and empties in one cycle on a flush.
module if_id_queue #(
  parameter int unsigned DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_ir,
  input  logic [31:0]              in_ra,
  output logic                     stall_if,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_ir,
  output logic [31:0]              out_ra,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] ra;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  // Occupancy flags and handshake qualifiers; full depends only on count so
  // the IF stall never sees a combinational path from ID's ready.
  always_comb begin
    full  = (count == CNT_W'(DEPTH));
    empty = (count == '0);
    push  = in_valid & ~full & ~flush;
    pop   = ~empty & out_ready & ~flush;
  end

  // Pointer and occupancy registers; reset beats flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Entry storage; contents are left untouched by reset and flush.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{pc: in_pc, ir: in_ir, ra: in_ra};
    end
  end

  // Head-of-queue view; an empty queue presents a NOP bubble to ID.
  always_comb begin
    stall_if  = full;
    out_valid = ~empty;
    out_pc    = '0;
    out_ir    = NOP;
    out_ra    = '0;
    if (!empty) begin
      out_pc = mem[rd_ptr].pc;
      out_ir = mem[rd_ptr].ir;
      out_ra = mem[rd_ptr].ra;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: every accepted push is queued as an
// expected head entry and compared whenever the queue should be presenting it.
module tb_if_id_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] ra;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_ir = '0;
  logic [31:0] in_ra = '0;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;
  logic        stall_if;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_ir;
  logic [31:0] out_ra;
  logic [$clog2(DEPTH):0] count;

  int   errors = 0;
  int   checks = 0;
  ent_t sb[$];
  bit   armed = 1'b0;
  logic [31:0] next_pc;

  if_id_queue #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_pc(in_pc), .in_ir(in_ir), .in_ra(in_ra),
    .stall_if(stall_if),
    .out_valid(out_valid), .out_pc(out_pc), .out_ir(out_ir), .out_ra(out_ra),
    .out_ready(out_ready), .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_ir(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check the head against the scoreboard,
  // then advance the scoreboard by what the queue should do at the next edge.
  task automatic cycle(input bit r, input bit iv, input logic [31:0] pc,
                       input bit rdy, input bit fl);
    bit   do_push;
    bit   do_pop;
    ent_t e;
    @(negedge clk);
    rst = r; in_valid = iv; in_pc = pc; in_ir = mk_ir(pc); in_ra = pc + 32'd4;
    out_ready = rdy; flush = fl;
    #1;
    if (armed) begin
      check_eq("count", 32'(count), 32'(sb.size()));
      check_eq("stall_if", 32'(stall_if), 32'(sb.size() == DEPTH));
      check_eq("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
        check_eq("out_pc", out_pc, sb[0].pc);
        check_eq("out_ir", out_ir, sb[0].ir);
        check_eq("out_ra", out_ra, sb[0].ra);
      end else begin
        check_eq("bubble_pc", out_pc, 32'h0);
        check_eq("bubble_ir", out_ir, NOP);
        check_eq("bubble_ra", out_ra, 32'h0);
      end
    end
    do_push = iv && (sb.size() < DEPTH) && !fl;
    do_pop  = (sb.size() != 0) && rdy && !fl;
    if (r) begin
      sb.delete();
      armed = 1'b1;
    end else if (fl) begin
      sb.delete();
    end else begin
      if (do_pop) e = sb.pop_front();
      if (do_push) begin
        e.pc = pc; e.ir = mk_ir(pc); e.ra = pc + 32'd4;
        sb.push_back(e);
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset then stream three instructions with ID always ready.
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 32'h4, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 32'h8, 1'b1, 1'b0);
    drain();

    // Fill under a decode stall; the fifth instruction must be refused.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b0);
    // Drain from full while IF holds 0x110 until it is accepted.
    cycle(1'b0, 1'b1, 32'h110, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 32'h110, 1'b1, 1'b0);
    drain();

    // Flush with simultaneous push and pop at count=3.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'h200 + 32'(i * 4), 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h20C, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 32'h300, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    drain();

    // Wrap-around: ten entries with random gaps in in_valid.
    next_pc = 32'h1000;
    for (int i = 0; i < 200 && next_pc < 32'h1028; i++) begin
      bit iv;
      bit acc;
      iv  = 1'($urandom_range(0, 1));
      acc = iv && (sb.size() < DEPTH);
      cycle(1'b0, iv, next_pc, 1'b1, 1'b0);
      if (acc) next_pc = next_pc + 32'd4;
    end
    check_eq("wrap_pushed", next_pc, 32'h1028);
    drain();

    // Random valid/ready with occasional flushes to exercise every occupancy.
    next_pc = 32'h2000;
    for (int i = 0; i < 80; i++) begin
      bit iv;
      bit rdy;
      bit fl;
      iv  = 1'($urandom_range(0, 3) != 0);
      rdy = 1'($urandom_range(0, 2) == 0);
      fl  = 1'($urandom_range(0, 19) == 0);
      cycle(1'b0, iv, next_pc, rdy, fl);
      next_pc = next_pc + 32'd4;
    end
    drain();

    // Reset mid-operation at count=2 with a push offered.
    cycle(1'b0, 1'b1, 32'h400, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h404, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h408, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 32'h500, 1'b1, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
